key_buffer: RTL
===============

KEY_BUFFER -- requirements
Module: key_buffer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4: key FIFO depth in entries, a power of two from 2 to 16.
REQ-002 The module SHALL have parameter DECIM, default 128: generator advance cycles between key captures, from 2 to 1024.
REQ-003 The module SHALL have port in_clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 The module SHALL have port in_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port in_lfsr, input, 128 bits: LFSR state from the upstream keys_generator.
REQ-006 The module SHALL have port in_enable, input, 1 bit: 1 = keys may be produced.
REQ-007 The module SHALL have port out_stop, output, 1 bit: drives the generator's in_stop; 1 = hold the generator.
REQ-008 The module SHALL have port out_key, output, 128 bits: head-of-FIFO key.
REQ-009 The module SHALL have port out_key_valid, output, 1 bit: out_key holds a valid key.
REQ-010 The module SHALL have port in_key_ready, input, 1 bit: consumer accepts out_key.
REQ-011 The module SHALL have port out_level, output, clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-012 The module SHALL have port out_zero_err, output, 1 bit: sticky flag for an all-zero (locked) LFSR capture.

Function
REQ-013 out_stop SHALL be combinational: in_rst OR NOT in_enable OR (out_level == DEPTH).
REQ-014 An advance cycle SHALL be any cycle with out_stop == 0; only advance cycles SHALL increment the decimation counter, which runs 0..DECIM-1 and wraps to 0.
REQ-015 A capture SHALL occur on an advance cycle with counter == DECIM-1, sampling in_lfsr in that cycle, before the generator's update at that edge.
REQ-016 A captured value equal to 128'd0 SHALL NOT be pushed; it SHALL set out_zero_err, and the counter SHALL still wrap to 0.
REQ-017 A non-zero capture SHALL be written to the FIFO tail, with out_level incremented at the same edge.
REQ-018 The FIFO SHALL be show-ahead: out_key_valid = (out_level != 0), and out_key = head entry when valid, otherwise 128'd0.
REQ-019 A pop SHALL occur when out_key_valid && in_key_ready; the head advances and out_level decrements at that edge.
REQ-020 A simultaneous push and pop SHALL leave out_level unchanged, with both pointers advancing.
REQ-021 When full, no capture SHALL occur because out_stop == 1, and the counter SHALL hold; a pop while full SHALL clear out_stop in the next cycle.
REQ-022 Deasserting in_enable SHALL freeze the counter at its current value, without clearing it; FIFO contents SHALL remain poppable.
REQ-023 Pointers SHALL wrap modulo DEPTH; out_level SHALL never exceed DEPTH or underflow.
REQ-024 Capture-to-valid latency SHALL be 1 cycle: out_key_valid is high in the cycle after a capture into an empty FIFO.
REQ-025 out_zero_err SHALL clear only on in_rst.

Reset
REQ-026 While in_rst is high, out_stop SHALL be 1.
REQ-027 At a clock edge with in_rst high: counter = 0, pointers = 0, out_level = 0, out_key_valid = 0, out_key = 0, out_zero_err = 0, and the whitening register = 0.
REQ-028 in_rst SHALL take priority over push and pop in the same cycle; FIFO entry contents need not be cleared.

Configuration
REQ-029 With macro KEY_WHITEN_EN defined, the pushed value SHALL be in_lfsr XOR the previous non-zero raw capture, held in a 128-bit register updated on each push; the first push after reset is therefore the raw value.
REQ-030 Without KEY_WHITEN_EN, the pushed value SHALL be raw in_lfsr and no whitening register SHALL exist; the zero check of REQ-016 SHALL apply to the raw capture in both builds.

Verification
REQ-031 DECIM=4, in_enable=1, in_key_ready=1, generator seeded 128'h1: first out_key_valid appears 5 cycles after reset release, out_key equals generator state after 3 advances, and keys recur every 4 cycles.
REQ-032 DEPTH=4, DECIM=4, in_key_ready=0: out_level reaches 4, out_stop=1, generator state frozen; one pop -> out_level=3 and out_stop=0 next cycle.
REQ-033 Generator left unseeded (state 0): out_zero_err=1 after DECIM advance cycles, out_level stays 0; in_rst clears the flag.
REQ-034 FIFO at level 2, push and pop in the same cycle: out_level stays 2, and keys emerge in capture order across pointer wrap after more than 8 pushes.
REQ-035 in_enable dropped at counter=2 for 10 cycles, then restored: capture occurs exactly 1 advance cycle after restore (DECIM=4).
REQ-036 KEY_WHITEN_EN build, raw captures A then B: pushed values are A, then A^B.

Source files
------------

// File: rtl/key_buffer.sv
// key_buffer: decimating key capture FIFO placed behind a free-running LFSR keys_generator.
//
// Every DECIM advance cycles it samples the generator state and pushes it into a show-ahead
// FIFO of DEPTH entries. It holds the generator (out_stop) while in reset, while disabled,
// or while the FIFO is full, so that no generator state is skipped unseen.
//
// Optional build macro: KEY_WHITEN_EN. When defined, each pushed key is the raw capture
// XORed with the previous non-zero raw capture.
//
// Ports:
//   in_clk        clock, rising edge
//   in_rst        synchronous active-high reset
//   in_lfsr       128-bit generator state
//   in_enable     1 = keys may be produced
//   out_stop      hold request to the generator (combinational)
//   out_key       head-of-FIFO key, zero when empty
//   out_key_valid out_key holds a valid key
//   in_key_ready  consumer accepts out_key
//   out_level     FIFO occupancy, 0..DEPTH
//   out_zero_err  sticky flag: an all-zero (locked) generator state was captured
module key_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DECIM = 128
) (
    input  logic                     in_clk,
    input  logic                     in_rst,
    input  logic [127:0]             in_lfsr,
    input  logic                     in_enable,
    output logic                     out_stop,
    output logic [127:0]             out_key,
    output logic                     out_key_valid,
    input  logic                     in_key_ready,
    output logic [$clog2(DEPTH):0]   out_level,
    output logic                     out_zero_err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned CntW = $clog2(DECIM);

    localparam logic [CntW-1:0] CntLast   = CntW'(DECIM - 1);
    localparam logic [LvlW-1:0] LevelFull = LvlW'(DEPTH);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic            zero_err_q, zero_err_d;
    logic [127:0]    mem_q [DEPTH];

    logic         advance;
    logic         capture;
    logic         cap_zero;
    logic         push;
    logic         pop;
    logic [127:0] push_data;

    // The generator moves on exactly the cycles the counter moves, so the
    // counter tracks generator advances one-for-one.
    assign out_stop = in_rst | ~in_enable | (level_q == LevelFull);
    assign advance  = ~out_stop;
    assign capture  = advance & (cnt_q == CntLast);
    assign cap_zero = capture & (in_lfsr == 128'd0);
    assign push     = capture & ~cap_zero;
    assign pop      = out_key_valid & in_key_ready;

`ifdef KEY_WHITEN_EN
    // Previous non-zero raw capture; zero after reset so the first key passes through raw.
    logic [127:0] whiten_q;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            whiten_q <= '0;
        end else if (push) begin
            whiten_q <= in_lfsr;
        end
    end

    assign push_data = in_lfsr ^ whiten_q;
`else
    assign push_data = in_lfsr;
`endif

    always_comb begin
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        zero_err_d = zero_err_q;

        if (advance) begin
            // A zero capture is dropped but still restarts the decimation period.
            cnt_d = capture ? '0 : cnt_q + 1'b1;
        end
        if (cap_zero) begin
            zero_err_d = 1'b1;
        end
        // DEPTH is a power of two, so pointers wrap by natural overflow.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Push is impossible when full (out_stop) and pop impossible when empty.
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            zero_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            zero_err_q <= zero_err_d;
        end
    end

    // Storage is not reset; out_key is masked to zero whenever the FIFO is empty.
    // push is already gated off during reset because out_stop is high.
    always_ff @(posedge in_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign out_key_valid = (level_q != '0);
    assign out_key       = out_key_valid ? mem_q[rd_ptr_q] : 128'd0;
    assign out_level     = level_q;
    assign out_zero_err  = zero_err_q;

endmodule
